// File: rtl/move_collector_pkg.sv
// move_collector_pkg: move word layout, flag positions, end-marker predicate and scan FSM encoding.
// Revision 1.0
`default_nettype none

package move_collector_pkg;

  localparam int NCOL    = 8;
  localparam int SLOTS   = 8;
  localparam int MW      = 19;
  localparam int WORD_W  = SLOTS * MW;
  localparam int PTR_W   = $clog2(NCOL);
  localparam int SLOT_IW = $clog2(SLOTS);

  localparam int BIT_INVALID   = 18;
  localparam int BIT_PROMOTE   = 17;
  localparam int BIT_PAWN      = 16;
  localparam int BIT_PAWN2     = 15;
  localparam int BIT_EP        = 14;
  localparam int BIT_CASTLE    = 13;
  localparam int BIT_CAPTURE   = 12;
  localparam int FROM_LSB      = 6;
  localparam int TO_LSB        = 0;
  localparam int SQ_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UNPACK = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A column ends its list with an invalid move whose from and to squares match.
  function automatic logic is_endmov(input logic [MW-1:0] m);
    return m[BIT_INVALID] && (m[FROM_LSB +: SQ_W] == m[TO_LSB +: SQ_W]);
  endfunction

  function automatic logic is_legal(input logic [MW-1:0] m);
    return !m[BIT_INVALID];
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_collector_unpacker.sv
// move_unpacker: walks one latched move word slot by slot and presents legal moves on valid/ready.
// Revision 1.0
`default_nettype none

module move_unpacker
  import move_collector_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              move_ready,
  output logic              move_valid,
  output logic [MW-1:0]     move_data,
  output logic              word_done,
  output logic              end_seen
);

  logic [WORD_W-1:0]  word_reg;
  logic [SLOT_IW-1:0] slot;
  logic               active;
  logic               can_issue;
  logic               last_slot;
  logic [MW-1:0]      cur;

  assign cur       = word_reg[32'(slot)*MW +: MW];
  // A slot may be consumed whenever the output register is empty or draining this cycle.
  assign can_issue = active && (!move_valid || move_ready);
  assign last_slot = (slot == SLOT_IW'(SLOTS-1));
  assign end_seen  = can_issue && is_endmov(cur);
  assign word_done = can_issue && !is_endmov(cur) && last_slot;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_reg   <= '0;
      slot       <= '0;
      active     <= 1'b0;
      move_valid <= 1'b0;
      move_data  <= '0;
    end else if (clear) begin
      active     <= 1'b0;
      move_valid <= 1'b0;
    end else begin
      if (move_valid && move_ready)
        move_valid <= 1'b0;
      if (load) begin
        word_reg <= word_in;
        slot     <= '0;
        active   <= 1'b1;
      end else if (can_issue) begin
        slot <= slot + 1'b1;
        if (end_seen || last_slot)
          active <= 1'b0;
        if (is_legal(cur)) begin
          move_data  <= cur;
          move_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_collector.sv
// move_collector: pops column move words in xpos order and streams legal moves; MVC_STATS_EN adds capture_count.
// Revision 1.0
`default_nettype none

module move_collector
  import move_collector_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NCOL-1:0]        col_valid,
  input  logic [NCOL*WORD_W-1:0] col_word,
  output logic [NCOL-1:0]        col_rden,
  output logic                   move_valid,
  output logic [MW-1:0]          move_data,
  input  logic                   move_ready,
  output logic [7:0]             move_count,
  output logic                   gen_done
`ifdef MVC_STATS_EN
  ,
  output logic [7:0]             capture_count
`endif
);

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [NCOL-1:0]   fin_mask;
  logic              accept;
  logic              word_done;
  logic              end_seen;
  logic [WORD_W-1:0] word_sel;

  assign accept   = move_valid & move_ready;
  assign word_sel = col_word[32'(ptr)*WORD_W +: WORD_W];

  // The word is captured on the edge that ends the registered pop strobe.
  move_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .load       (|col_rden),
    .word_in    (word_sel),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_data  (move_data),
    .word_done  (word_done),
    .end_seen   (end_seen)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      fin_mask   <= '0;
      col_rden   <= '0;
      move_count <= '0;
      gen_done   <= 1'b0;
    end else if (start) begin
      state      <= ST_SCAN;
      ptr        <= '0;
      fin_mask   <= '0;
      col_rden   <= '0;
      move_count <= '0;
      gen_done   <= 1'b0;
    end else begin
      col_rden <= '0;
      if (accept && move_count != 8'hFF)
        move_count <= move_count + 8'd1;
      case (state)
        ST_SCAN: begin
          if (&fin_mask)
            state <= ST_DONE;
          else if (fin_mask[ptr])
            ptr <= ptr + 1'b1;
          else if (col_valid[ptr]) begin
            col_rden <= NCOL'(1) << ptr;
            state    <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          if (end_seen) begin
            fin_mask[ptr] <= 1'b1;
            ptr           <= ptr + 1'b1;
            state         <= ST_SCAN;
          end else if (word_done) begin
            state <= ST_SCAN;
          end
        end
        ST_DONE:
          gen_done <= gen_done | ~move_valid;
        default: ;
      endcase
    end
  end

`ifdef MVC_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset || start)
      capture_count <= '0;
    else if (accept && move_data[BIT_CAPTURE] && capture_count != 8'hFF)
      capture_count <= capture_count + 8'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_move_collector.sv
// tb_move_collector: scoreboard bench for move_collector (covers MVC_STATS_EN when defined).
// Revision 1.0
`default_nettype none

module tb_move_collector;

  localparam int NC = 8;
  localparam int WW = 152;
  localparam logic [18:0] ENDM = {1'b1, 6'b0, 6'd5, 6'd5};
  localparam logic [18:0] GAP  = {1'b1, 6'b0, 6'd1, 6'd2};

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NC-1:0]  col_valid;
  logic [NC*WW-1:0] col_word;
  logic [NC-1:0]  col_rden;
  logic           move_valid;
  logic [18:0]    move_data;
  logic           move_ready;
  logic [7:0]     move_count;
  logic           gen_done;
`ifdef MVC_STATS_EN
  logic [7:0]     capture_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WW-1:0] colq [NC][$];
  logic [18:0]   exp_q [$];
  logic [NC-1:0] blk;
  logic [NC-1:0] rd_s;

  move_collector dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .col_valid  (col_valid),
    .col_word   (col_word),
    .col_rden   (col_rden),
    .move_valid (move_valid),
    .move_data  (move_data),
    .move_ready (move_ready),
    .move_count (move_count),
    .gen_done   (gen_done)
`ifdef MVC_STATS_EN
    ,
    .capture_count (capture_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] lm(input int f, input int t, input bit cap = 1'b0);
    return {1'b0, 5'b0, cap, 6'(f), 6'(t)};
  endfunction

  function automatic logic [WW-1:0] pack(input logic [18:0] s [8]);
    logic [WW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*19 +: 19] = s[k];
    return w;
  endfunction

  // Queue a word on a column and record the moves it should yield (words added in column order).
  task automatic add_word(input int c, input logic [WW-1:0] w);
    logic [18:0] m;
    colq[c].push_back(w);
    for (int k = 0; k < 8; k++) begin
      m = w[k*19 +: 19];
      if (m[18] && m[11:6] == m[5:0]) break;
      if (!m[18]) exp_q.push_back(m);
    end
  endtask

  task automatic end_all(input int first);
    logic [18:0] s [8];
    for (int k = 0; k < 8; k++) s[k] = ENDM;
    for (int c = first; c < NC; c++) add_word(c, pack(s));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!gen_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("gen_done", 32'(gen_done), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!move_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("first_valid_seen", 32'(move_valid), 32'd1);
  endtask

  // Show-ahead FIFO model: pops on the edge that ends a strobe seen high.
  initial begin
    col_valid = '0;
    col_word  = '0;
    forever begin
      @(negedge clk);
      rd_s = col_rden;
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        if (rd_s[c] && colq[c].size() > 0) void'(colq[c].pop_front());
        col_valid[c] = (colq[c].size() > 0) && !blk[c];
        col_word[c*WW +: WW] = (colq[c].size() > 0) ? colq[c][0] : '0;
      end
    end
  end

  always @(negedge clk) begin
    logic [18:0] e;
    if (reset && move_valid && move_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_move", 32'(move_data), 32'h7FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_move", 32'(move_data), 32'(e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] s [8];
    logic [18:0] d0;
    int r;
    reset = 1'b0; start = 1'b0; move_ready = 1'b1; blk = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(move_valid), 32'd0);
    check("rst_data", 32'(move_data), 32'd0);
    check("rst_count", 32'(move_count), 32'd0);
    check("rst_done", 32'(gen_done), 32'd0);
    check("rst_rden", 32'(col_rden), 32'd0);
`ifdef MVC_STATS_EN
    check("rst_capture", 32'(capture_count), 32'd0);
`endif
    reset = 1'b1;

    // Idle without start must never pop.
    colq[0].push_back('1);
    r = 0;
    repeat (6) begin @(negedge clk); if (col_rden != 0) r++; end
    check("idle_no_pop", 32'(r), 32'd0);
    colq[0].delete();
    repeat (2) @(negedge clk);

    // Three legal moves then marker; trailing slots discarded.
    s = '{lm(8,16), lm(9,17,1'b1), lm(10,18), ENDM, lm(1,2), lm(3,4), lm(5,6), lm(7,8)};
    add_word(0, pack(s));
    end_all(1);
    pulse_start();
    wait_done(300);
    check("t1_count", 32'(move_count), 32'd3);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef MVC_STATS_EN
    check("t1_capture", 32'(capture_count), 32'd1);
`endif

    // Invalid non-marker slot dropped; column continues with a second word.
    s = '{lm(8,16), GAP, lm(9,17), lm(10,18), lm(11,19), lm(12,20), lm(13,21), lm(14,22)};
    add_word(0, pack(s));
    s = '{lm(20,28), ENDM, lm(0,0), lm(0,0), lm(0,0), lm(0,0), lm(0,0), lm(0,0)};
    add_word(0, pack(s));
    end_all(1);
    pulse_start();
    wait_done(300);
    check("t2_count", 32'(move_count), 32'd8);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on first move.
    move_ready = 1'b0;
    s = '{lm(8,16), lm(9,17), lm(10,18), ENDM, ENDM, ENDM, ENDM, ENDM};
    add_word(0, pack(s));
    end_all(1);
    pulse_start();
    wait_valid(50);
    d0 = move_data;
    check("t3_first_data", 32'(d0), 32'(lm(8,16)));
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", 32'(move_data), 32'(d0));
      check("t3_hold_no_pop", 32'(col_rden), 32'd0);
      check("t3_hold_count", 32'(move_count), 32'd0);
    end
    move_ready = 1'b1;
    @(negedge clk);
    check("t3_count_release", 32'(move_count), 32'd1);
    wait_done(300);
    check("t3_count", 32'(move_count), 32'd3);

    // Column 3 stalled while column 4 has data: strict order.
    blk[3] = 1'b1;
    for (int c = 0; c < NC; c++) begin
      s = '{lm(c, c+8), ENDM, ENDM, ENDM, ENDM, ENDM, ENDM, ENDM};
      add_word(c, pack(s));
    end
    pulse_start();
    r = 0;
    repeat (30) begin @(negedge clk); if (col_rden[4]) r++; end
    check("t4_no_col4_pop", 32'(r), 32'd0);
    check("t4_count_stalled", 32'(move_count), 32'd3);
    check("t4_not_done", 32'(gen_done), 32'd0);
    blk[3] = 1'b0;
    wait_done(300);
    check("t4_count", 32'(move_count), 32'd8);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort mid-UNPACK with a move pending.
    move_ready = 1'b0;
    s = '{lm(1,9), lm(2,10), lm(3,11), lm(4,12), lm(5,13), lm(6,14), lm(7,15), lm(8,16)};
    add_word(0, pack(s));
    end_all(1);
    pulse_start();
    wait_valid(50);
    for (int c = 0; c < NC; c++) colq[c].delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    pulse_start();
    check("t5_valid_dropped", 32'(move_valid), 32'd0);
    check("t5_count_cleared", 32'(move_count), 32'd0);
    check("t5_no_pop", 32'(col_rden), 32'd0);
    s = '{lm(40,48), ENDM, ENDM, ENDM, ENDM, ENDM, ENDM, ENDM};
    add_word(0, pack(s));
    end_all(1);
    move_ready = 1'b1;
    wait_done(300);
    check("t5_count", 32'(move_count), 32'd1);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 256 capture moves: counters saturate.
    for (int w = 0; w < 32; w++) begin
      for (int k = 0; k < 8; k++) s[k] = lm(w, k + 8, 1'b1);
      add_word(0, pack(s));
    end
    for (int k = 0; k < 8; k++) s[k] = ENDM;
    add_word(0, pack(s));
    end_all(1);
    pulse_start();
    wait_done(3000);
    check("t6_count_sat", 32'(move_count), 32'd255);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef MVC_STATS_EN
    check("t6_capture_sat", 32'(capture_count), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
